video_pattern_scheduler: RTL and testbench

Frame-synchronous scheduler for the RGB111 test-pattern generators in the 576i video path. It selects which pattern generator drives the output, and accepts pattern-change requests from the host over a valid/ready handshake. An optional auto-cycle mode steps through the patterns on a fixed frame dwell. All switches happen on field boundaries and are masked by a configurable number of muted (black) fields, so no partial or torn pattern is ever displayed.

---
 rtl/video_pattern_scheduler.sv | 100 ++++++++++
 tb/tb_video_pattern_scheduler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/video_pattern_scheduler.sv
// Field-synchronous pattern selector for the RGB111 test-pattern path; host requests and
// auto-cycle steps are applied on vsyncStart and masked by BLANK_FRAMES muted fields.
module video_pattern_scheduler #(
  parameter int NUM_PATTERNS = 4,
  parameter int DWELL_FRAMES = 50,
  parameter int BLANK_FRAMES = 1
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       vsyncStart,
  input  logic       autoCycle,
  input  logic       reqValid,
  input  logic [2:0] reqPattern,
  output logic       reqReady,
  output logic [2:0] patternSel,
  output logic       muteVideo,
  output logic       patternChanged
);

  localparam logic [2:0] LAST_PATTERN = 3'(NUM_PATTERNS - 1);
  localparam logic [3:0] PATTERN_LIMIT = 4'(NUM_PATTERNS);
  localparam logic [9:0] DWELL_LAST = 10'(DWELL_FRAMES - 1);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES - 1);

  typedef enum logic [1:0] {RUN, PEND, BLANK} state_t;

  state_t     state;
  logic [2:0] nextPattern;
  logic [9:0] dwellCount;
  logic [3:0] blankCount;
  logic [2:0] autoPattern;
  logic       reqInRange;

  assign autoPattern = (patternSel == LAST_PATTERN) ? 3'd0 : patternSel + 3'd1;
  assign reqInRange  = ({1'b0, reqPattern} < PATTERN_LIMIT);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state          <= BLANK;
      nextPattern    <= 3'd0;
      dwellCount     <= 10'd0;
      blankCount     <= 4'd0;
      patternSel     <= 3'd0;
      muteVideo      <= 1'b1;
      reqReady       <= 1'b0;
      patternChanged <= 1'b0;
    end else begin
      patternChanged <= 1'b0;
      case (state)
        RUN: begin
          // Any completed handshake, even an out-of-range one, outranks the auto step.
          if (reqValid && reqReady) begin
            if (reqInRange) begin
              nextPattern <= reqPattern;
              dwellCount  <= 10'd0;
              reqReady    <= 1'b0;
              state       <= PEND;
            end
          end else if (!autoCycle) begin
            dwellCount <= 10'd0;
          end else if (vsyncStart) begin
            if (dwellCount == DWELL_LAST) begin
              nextPattern <= autoPattern;
              patternSel  <= autoPattern;
              muteVideo   <= 1'b1;
              blankCount  <= 4'd0;
              dwellCount  <= 10'd0;
              reqReady    <= 1'b0;
              state       <= BLANK;
            end else begin
              dwellCount <= dwellCount + 10'd1;
            end
          end
        end
        PEND: begin
          if (vsyncStart) begin
            patternSel <= nextPattern;
            muteVideo  <= 1'b1;
            blankCount <= 4'd0;
            state      <= BLANK;
          end
        end
        BLANK: begin
          if (vsyncStart) begin
            if (blankCount == BLANK_LAST) begin
              muteVideo      <= 1'b0;
              patternChanged <= 1'b1;
              reqReady       <= 1'b1;
              state          <= RUN;
            end else begin
              blankCount <= blankCount + 4'd1;
            end
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Directed bench for video_pattern_scheduler (NUM_PATTERNS=4, DWELL_FRAMES=3, BLANK_FRAMES=1).
module tb_video_pattern_scheduler;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       vsyncStart = 1'b0;
  logic       autoCycle = 1'b0;
  logic       reqValid = 1'b0;
  logic [2:0] reqPattern = 3'd0;
  logic       reqReady;
  logic [2:0] patternSel;
  logic       muteVideo;
  logic       patternChanged;

  int vectors = 0;
  int miscompares = 0;

  video_pattern_scheduler #(
    .NUM_PATTERNS(4),
    .DWELL_FRAMES(3),
    .BLANK_FRAMES(1)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .vsyncStart(vsyncStart),
    .autoCycle(autoCycle),
    .reqValid(reqValid),
    .reqPattern(reqPattern),
    .reqReady(reqReady),
    .patternSel(patternSel),
    .muteVideo(muteVideo),
    .patternChanged(patternChanged)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOut(input string tag, input int sel, input int mute, input int rdy, input int chg);
    checkVal({tag, ".sel"}, int'(patternSel), sel);
    checkVal({tag, ".mute"}, int'(muteVideo), mute);
    checkVal({tag, ".rdy"}, int'(reqReady), rdy);
    checkVal({tag, ".chg"}, int'(patternChanged), chg);
  endtask

  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic pulseVsync();
    vsyncStart = 1'b1;
    @(negedge clk);
    vsyncStart = 1'b0;
  endtask

  task automatic request(input logic [2:0] pat);
    reqValid   = 1'b1;
    reqPattern = pat;
    @(negedge clk);
    reqValid   = 1'b0;
  endtask

  // patternSel and muteVideo after each of 16 auto-cycle fields, starting from pattern 0, dwell 0.
  int autoSel [16] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0};
  int autoMute[16] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    repeat (3) @(negedge clk);
    checkOut("reset", 0, 1, 0, 0);
    nReset = 1'b1;
    @(negedge clk);
    checkOut("postReset", 0, 1, 0, 0);
    pulseVsync();
    checkOut("firstUnmute", 0, 0, 1, 1);
    @(negedge clk);
    checkVal("firstChgPulse", int'(patternChanged), 0);

    request(3'd2);
    checkOut("req2.accept", 0, 0, 0, 0);
    pulseVsync();
    checkOut("req2.blank", 2, 1, 0, 0);
    pulseVsync();
    checkOut("req2.show", 2, 0, 1, 1);

    request(3'd5);
    checkOut("req5.discard", 2, 0, 1, 0);
    pulseVsync();
    checkOut("req5.noSwitch", 2, 0, 1, 0);

    request(3'd0);
    pulseVsync();
    pulseVsync();
    checkOut("req0.show", 0, 0, 1, 1);

    autoCycle = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pulseVsync();
      checkVal($sformatf("auto%0d.sel", k + 1), int'(patternSel), autoSel[k]);
      checkVal($sformatf("auto%0d.mute", k + 1), int'(muteVideo), autoMute[k]);
      repeat (2) @(negedge clk);
    end

    // Bring dwellCount to DWELL_FRAMES-1, then collide a request with the terminal vsync.
    pulseVsync();
    pulseVsync();
    checkOut("coinc.pre", 0, 0, 1, 0);
    reqValid   = 1'b1;
    reqPattern = 3'd3;
    vsyncStart = 1'b1;
    @(negedge clk);
    reqValid   = 1'b0;
    vsyncStart = 1'b0;
    checkOut("coinc.accept", 0, 0, 0, 0);
    pulseVsync();
    checkOut("coinc.blank", 3, 1, 0, 0);
    pulseVsync();
    checkOut("coinc.show", 3, 0, 1, 1);
    pulseVsync();
    pulseVsync();
    checkOut("coinc.dwell2", 3, 0, 1, 0);
    pulseVsync();
    checkOut("coinc.autoStep", 0, 1, 0, 0);
    pulseVsync();
    checkOut("coinc.autoShow", 0, 0, 1, 1);

    autoCycle = 1'b0;
    request(3'd3);
    checkOut("pend.accept", 0, 0, 0, 0);
    #2 nReset = 1'b0;
    #1;
    checkOut("asyncReset", 0, 1, 0, 0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    pulseVsync();
    checkOut("lostReq.show", 0, 0, 1, 1);
    pulseVsync();
    checkOut("lostReq.hold", 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
